// File: rtl/sicobi_mem_pkg.sv
// Shared types and helpers for the SiCoBi memory responder.
// Holds the FSM state encoding, the LFSR tap mask and the wait-target calculation.
package sicobi_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT
    } state_e;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right.
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    function automatic int unsigned waitTarget(input int unsigned waitCycles,
                                               input int unsigned randBits,
                                               input logic [15:0] lfsr);
        logic [15:0] mask;
        mask = (randBits == 0) ? 16'h0000 : 16'((32'd1 << randBits) - 32'd1);
        return waitCycles + 32'(lfsr & mask);
    endfunction

endpackage

// File: rtl/sicobi_lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle with step_i high.
// Reset loads SEED, which must be nonzero.
module sicobi_lfsr16
    import sicobi_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR16_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/sicobi_mem_responder.sv
// Single-port memory model for the SiCoBi memory-driver protocol with
// fixed plus pseudo-random wait states and a post-reset clear sweep.
module sicobi_mem_responder
    import sicobi_mem_pkg::*;
#(
    parameter int unsigned       WIDTH          = 16,
    parameter int unsigned       HEIGHT         = 16,
    parameter int unsigned       WAIT_CYCLES    = 0,
    parameter int unsigned       RAND_WAIT_BITS = 0,
    parameter logic [15:0]       LFSR_SEED      = 16'hACE1,
    parameter logic [WIDTH-1:0]  INIT_VALUE     = '0,
    localparam int unsigned      AW             = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             isWrite_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic [AW-1:0]    addr_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             hold_o,
    output logic             busy_o,
    output logic             error_o
);

    localparam int unsigned TMAX = WAIT_CYCLES + (32'd1 << RAND_WAIT_BITS) - 1;
    localparam int unsigned CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    state_e           state_q;
    logic [AW-1:0]    clrPtr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    tgt;
    logic [15:0]      lfsrVal;
    logic             addrOk, accept, memWe;
    logic [AW-1:0]    memAddr;
    logic [WIDTH-1:0] memWdata;
    logic [WIDTH-1:0] mem_q [HEIGHT];

    // The LFSR only moves when a request starts, so idle time never shifts the T sequence.
    sicobi_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .step_i ((state_q == IDLE) && enable_i),
        .value_o(lfsrVal)
    );

    assign tgt    = CW'(waitTarget(WAIT_CYCLES, RAND_WAIT_BITS, lfsrVal));
    assign addrOk = 32'(addr_i) < HEIGHT;

    always_comb begin
        hold_o = 1'b1;
        case (state_q)
            IDLE:    hold_o = enable_i && (tgt != '0);
            WAIT:    hold_o = (cnt_q != '0);
            default: hold_o = 1'b1;
        endcase
    end

    assign accept = enable_i && !hold_o && (state_q != CLEAR);
    assign busy_o = (state_q == CLEAR);

    // The clear sweep shares the single write port with normal accepts.
    assign memWe    = (state_q == CLEAR) || (accept && isWrite_i && addrOk);
    assign memAddr  = (state_q == CLEAR) ? clrPtr_q : addr_i;
    assign memWdata = (state_q == CLEAR) ? INIT_VALUE : wrData_i;

    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[memAddr] <= memWdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CLEAR;
            clrPtr_q <= '0;
            cnt_q    <= '0;
            rdData_o <= '0;
            error_o  <= 1'b0;
        end else begin
            if (accept && !isWrite_i) begin
                rdData_o <= addrOk ? mem_q[addr_i] : '0;
            end
            if (accept && !addrOk) begin
                error_o <= 1'b1;
            end
            case (state_q)
                CLEAR: begin
                    clrPtr_q <= clrPtr_q + 1'b1;
                    if (clrPtr_q == AW'(HEIGHT - 1)) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (enable_i && (tgt != '0)) begin
                        cnt_q   <= tgt - 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable_i) begin
                        error_o <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sicobi_mem_responder.sv
// Self-checking bench: four responder configurations share one stimulus bus;
// each scenario checks the instance it targets against a behavioural model.
module tb_sicobi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        wr  = 1'b0;
    logic [15:0] wd  = 16'h0;
    logic [3:0]  ad  = 4'h0;

    logic [15:0] rd_w   [4];
    logic        hold_w [4];
    logic        busy_w [4];
    logic        err_w  [4];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    // A: plain, INIT 5A5A
    sicobi_mem_responder #(.WIDTH(16), .HEIGHT(16), .WAIT_CYCLES(0), .RAND_WAIT_BITS(0),
                           .LFSR_SEED(16'hACE1), .INIT_VALUE(16'h5A5A)) u_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .isWrite_i(wr), .wrData_i(wd), .addr_i(ad),
        .rdData_o(rd_w[0]), .hold_o(hold_w[0]), .busy_o(busy_w[0]), .error_o(err_w[0]));
    // B: fixed wait of 3
    sicobi_mem_responder #(.WIDTH(16), .HEIGHT(16), .WAIT_CYCLES(3), .RAND_WAIT_BITS(0),
                           .LFSR_SEED(16'hACE1), .INIT_VALUE(16'h0000)) u_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .isWrite_i(wr), .wrData_i(wd), .addr_i(ad),
        .rdData_o(rd_w[1]), .hold_o(hold_w[1]), .busy_o(busy_w[1]), .error_o(err_w[1]));
    // C: random wait, 2 bits
    sicobi_mem_responder #(.WIDTH(16), .HEIGHT(16), .WAIT_CYCLES(0), .RAND_WAIT_BITS(2),
                           .LFSR_SEED(16'hACE1), .INIT_VALUE(16'h0000)) u_c (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .isWrite_i(wr), .wrData_i(wd), .addr_i(ad),
        .rdData_o(rd_w[2]), .hold_o(hold_w[2]), .busy_o(busy_w[2]), .error_o(err_w[2]));
    // D: HEIGHT 12, fixed wait of 4
    sicobi_mem_responder #(.WIDTH(16), .HEIGHT(12), .WAIT_CYCLES(4), .RAND_WAIT_BITS(0),
                           .LFSR_SEED(16'hACE1), .INIT_VALUE(16'h0000)) u_d (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .isWrite_i(wr), .wrData_i(wd), .addr_i(ad),
        .rdData_o(rd_w[3]), .hold_o(hold_w[3]), .busy_o(busy_w[3]), .error_o(err_w[3]));

    // Reference LFSR: Galois x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int k, input int expBusy);
        int n;
        n = 0;
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (rd_w[k] !== 16'h0000 || err_w[k] !== 1'b0) begin
            miss++;
            $display("FAIL reset_state[%0d]: rd=%h err=%b, want rd=0000 err=0", k, rd_w[k], err_w[k]);
        end
        while (busy_w[k] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        vec++;
        if (n !== expBusy) begin
            miss++;
            $display("FAIL busy_len[%0d]: got %0d cycles, want %0d", k, n, expBusy);
        end
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns the hold count and rdData_o one cycle after accept.
    // enable_i is left high so a following call runs back-to-back.
    task automatic do_req(input int k, input logic w, input logic [3:0] a, input logic [15:0] d,
                          output int holds, output logic [15:0] rdata);
        holds = 0;
        en = 1'b1;
        wr = w;
        ad = a;
        wd = d;
        @(negedge clk);
        while (hold_w[k] === 1'b1 && holds < 64) begin
            holds++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdata = rd_w[k];
    endtask

    task automatic test_reset();
        int h;
        logic [15:0] r;
        do_reset(0, 16);
        for (int i = 0; i < 16; i++) begin
            do_req(0, 1'b0, 4'(i), 16'h0, h, r);
            vec++;
            if (h !== 0 || r !== 16'h5A5A) begin
                miss++;
                $display("FAIL clear_read@%0d: hold=%0d data=%h, want hold=0 data=5a5a", i, h, r);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int h1, h2;
        logic [15:0] r;
        do_reset(0, 16);
        do_req(0, 1'b1, 4'd3, 16'h1234, h1, r);
        do_req(0, 1'b0, 4'd3, 16'h0, h2, r);
        idle(1);
        vec++;
        if (h1 !== 0 || h2 !== 0 || r !== 16'h1234) begin
            miss++;
            $display("FAIL b2b_wr_rd: holds=%0d/%0d data=%h, want 0/0 1234", h1, h2, r);
        end
    endtask

    task automatic test_fixed_wait();
        int h;
        logic [15:0] r;
        do_reset(1, 16);
        do_req(1, 1'b1, 4'd5, 16'hBEEF, h, r);
        idle(1);
        vec++;
        if (h !== 3) begin
            miss++;
            $display("FAIL fixed_wr_hold: got %0d, want 3", h);
        end
        do_req(1, 1'b0, 4'd5, 16'h0, h, r);
        vec++;
        if (h !== 3 || r !== 16'hBEEF) begin
            miss++;
            $display("FAIL fixed_rd: hold=%0d data=%h, want 3 beef", h, r);
        end
        do_req(1, 1'b1, 4'd5, 16'h1111, h, r);
        idle(1);
        vec++;
        if (h !== 3 || r !== 16'hBEEF) begin
            miss++;
            $display("FAIL rd_kept_over_wr: hold=%0d data=%h, want 3 beef", h, r);
        end
        do_req(1, 1'b0, 4'd5, 16'h0, h, r);
        idle(1);
        vec++;
        if (r !== 16'h1111) begin
            miss++;
            $display("FAIL fixed_rd2: data=%h, want 1111", r);
        end
    endtask

    task automatic test_rand_wait();
        int h;
        int first [8];
        logic [15:0] r;
        logic [15:0] lf;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(2, 16);
            lf = 16'hACE1;
            for (int i = 0; i < 8; i++) begin
                do_req(2, 1'b0, 4'(i), 16'h0, h, r);
                if (pass == 1) idle($urandom_range(0, 3));
                vec++;
                if (h !== int'(lf & 16'h3)) begin
                    miss++;
                    $display("FAIL rand_hold p%0d r%0d: got %0d, want %0d", pass, i, h, lf & 16'h3);
                end
                if (pass == 0) begin
                    first[i] = h;
                end else begin
                    vec++;
                    if (h !== first[i]) begin
                        miss++;
                        $display("FAIL rand_gap_invariant r%0d: got %0d, want %0d", i, h, first[i]);
                    end
                end
                lf = lfsr_next(lf);
            end
            idle(1);
        end
    endtask

    task automatic test_random_traffic();
        int h;
        logic [15:0] r, d, lf;
        logic [15:0] mem_m [16];
        logic w;
        logic [3:0] a;
        do_reset(2, 16);
        lf = 16'hACE1;
        for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            do_req(2, w, a, d, h, r);
            vec++;
            if (h !== int'(lf & 16'h3) || (!w && r !== mem_m[a])) begin
                miss++;
                $display("FAIL traffic#%0d %s@%0d: hold=%0d data=%h, want hold=%0d data=%h",
                         i, w ? "wr" : "rd", a, h, r, lf & 16'h3, mem_m[a]);
            end
            if (w) mem_m[a] = d;
            lf = lfsr_next(lf);
            idle($urandom_range(0, 2));
        end
        idle(1);
    endtask

    task automatic test_addr_error();
        int h;
        logic [15:0] r;
        do_reset(3, 12);
        do_req(3, 1'b1, 4'd1, 16'h7777, h, r);
        idle(1);
        vec++;
        if (h !== 4 || err_w[3] !== 1'b0) begin
            miss++;
            $display("FAIL ok_write: hold=%0d err=%b, want 4 0", h, err_w[3]);
        end
        do_req(3, 1'b1, 4'd13, 16'h1234, h, r);
        idle(1);
        vec++;
        if (err_w[3] !== 1'b1) begin
            miss++;
            $display("FAIL oob_write_err: err=%b, want 1", err_w[3]);
        end
        do_req(3, 1'b0, 4'd13, 16'h0, h, r);
        idle(1);
        vec++;
        if (r !== 16'h0000) begin
            miss++;
            $display("FAIL oob_read: data=%h, want 0000", r);
        end
        do_req(3, 1'b0, 4'd1, 16'h0, h, r);
        idle(1);
        vec++;
        if (r !== 16'h7777 || err_w[3] !== 1'b1) begin
            miss++;
            $display("FAIL mem1_intact: data=%h err=%b, want 7777 1", r, err_w[3]);
        end
    endtask

    task automatic test_protocol();
        int h;
        logic [15:0] r;
        do_reset(3, 12);
        en = 1'b1; wr = 1'b1; ad = 4'd2; wd = 16'h5555;
        tick();
        tick();
        en = 1'b0;
        tick();
        vec++;
        if (err_w[3] !== 1'b1 || hold_w[3] !== 1'b0) begin
            miss++;
            $display("FAIL drop_enable: err=%b hold=%b, want 1 0", err_w[3], hold_w[3]);
        end
        do_req(3, 1'b0, 4'd2, 16'h0, h, r);
        idle(1);
        vec++;
        if (h !== 4 || r !== 16'h0000) begin
            miss++;
            $display("FAIL dropped_no_write: hold=%0d data=%h, want 4 0000", h, r);
        end
        en = 1'b1; wr = 1'b0; ad = 4'd2;
        tick();
        tick();
        vec++;
        if (err_w[3] !== 1'b1 || busy_w[3] !== 1'b0) begin
            miss++;
            $display("FAIL pre_reset: err=%b busy=%b, want 1 0", err_w[3], busy_w[3]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        vec++;
        if (busy_w[3] !== 1'b1 || err_w[3] !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid_wait: busy=%b err=%b, want 1 0", busy_w[3], err_w[3]);
        end
        repeat (20) tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_back_to_back();
        test_fixed_wait();
        test_rand_wait();
        test_random_traffic();
        test_addr_error();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "timeout");
    end

endmodule
